adc_align_ctrl: RTL and testbench
=================================

# adc_align_ctrl

Frame-alignment controller for the ADC LVDS capture path, running in the CLKDIV (DCLK/4) domain. It sequences ISERDES reset, searches for the frame-clock pattern by issuing single-cycle bitslip pulses with settle gaps, and qualifies lock. It then monitors lock and re-aligns on sustained loss. The bitslip output is shared by the frame deserializer and all data-lane deserializers, so every lane slips in step.

## Interface
Parameters:
- FRAME_PATTERN, 8'hF0: expected deserialized FCO word when aligned.
- RST_CYC, 8: cycles ISERDES reset is held.
- SETTLE_CYC, 4: wait cycles after reset or after each slip before comparing.
- MAX_SLIPS, 8: slips attempted before declaring failure.
- LOCK_CNT, 16: consecutive matches required to declare lock.
- ERR_LIMIT, 4: consecutive mismatches while locked that force re-alignment.

Ports:
- CLKDIV  in  1  divided capture clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- adc_en  in  1  alignment enable; low forces IDLE.
- frmData  in  8  deserialized FCO word, one per CLKDIV cycle.
- iserdes_rst  out  1  reset to all ISERDES instances.
- bitslip  out  1  single-cycle slip pulse to all ISERDES instances.
- locked  out  1  alignment qualified; downstream sample valid.
- align_fail  out  1  no alignment found within MAX_SLIPS.
- slip_count  out  4  slips issued in the current search.

## Operation
- States: IDLE, SRST, SETTLE, CHECK, SLIP, VERIFY, LOCKED, FAIL.
- Reset: state=IDLE. iserdes_rst=1 while RST is high and in IDLE; all other outputs 0. Internal counters 0.
- IDLE: iserdes_rst=1. adc_en=1 -> SRST, with slip_count cleared.
- SRST: iserdes_rst=1 for RST_CYC cycles -> SETTLE.
- SETTLE: count SETTLE_CYC cycles -> CHECK. iserdes_rst=0.
- CHECK, one cycle:
  - frmData==FRAME_PATTERN -> VERIFY.
  - Mismatch and slip_count<MAX_SLIPS -> SLIP.
  - Otherwise -> FAIL.
- SLIP: bitslip=1 for exactly one cycle, slip_count+1 -> SETTLE. bitslip is never high on two consecutive cycles.
- VERIFY: match counter increments on each match.
  - Counter reaches LOCK_CNT -> LOCKED.
  - Any mismatch -> SLIP if slip_count<MAX_SLIPS, else FAIL. The match counter clears.
- LOCKED: locked=1. An error counter counts consecutive mismatches and clears on any match.
  - Error counter reaches ERR_LIMIT -> SETTLE, with locked=0, slip_count=0, no ISERDES reset.
  - Isolated mismatches (<ERR_LIMIT) do not drop lock.
- FAIL: align_fail=1 and holds until adc_en=0 or RST.
- adc_en=0 in any state -> IDLE on the next edge. locked, align_fail and bitslip clear that edge.
- RST has priority over adc_en.
- slip_count saturates at MAX_SLIPS and is held (not cleared) in LOCKED and FAIL.

## Timing
- All outputs are registered and change only on the CLKDIV rising edge.
- Best case (pattern already aligned), with adc_en sampled high at edge 0:
  - iserdes_rst is high through edge RST_CYC.
  - The first compare occurs at edge RST_CYC+SETTLE_CYC+1.
  - locked rises at edge RST_CYC+SETTLE_CYC+LOCK_CNT+2, which is 30 with the defaults.
- Each slip costs 1+SETTLE_CYC+1 cycles before the next compare.
- Loss of lock: locked falls on the edge after the ERR_LIMIT-th consecutive mismatch.
- Simultaneous events:
  - adc_en falling wins over any transition out of CHECK, VERIFY or LOCKED.
  - RST mid-slip drops bitslip on that edge.

## Configuration
- ADC_ALIGN_STATS_EN defined:
  - Adds output relock_count (8 bits, saturating at 255), reset to 0 by RST only.
  - relock_count increments on each LOCKED->SETTLE transition.
  - Adds output fail_count (8 bits, saturating), which increments on each entry to FAIL.
- ADC_ALIGN_STATS_EN undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Aligned stream: frmData constant 8'hF0, adc_en rises -> locked=1 at edge 30, bitslip never pulses, slip_count=0.
- Misaligned by 3: frmData is FRAME_PATTERN rotated left by (3−slips issued) -> exactly 3 single-cycle bitslip pulses, each separated by ≥SETTLE_CYC+1 cycles; locked=1 with slip_count=3.
- No pattern: frmData=8'hAA forever -> 8 slips, then align_fail=1 and locked=0. Dropping adc_en -> IDLE with align_fail=0 next edge.
- Lock-loss tolerance: while locked, inject 3 mismatches then a match -> locked stays 1. Inject 4 consecutive mismatches -> locked=0 on the next edge, re-search starts without iserdes_rst; with ADC_ALIGN_STATS_EN, relock_count=1.
- VERIFY glitch: one mismatch at match 10 of 16 -> one bitslip, the match counter restarts, and lock is qualified only after 16 fresh matches.
- RST asserted during SLIP and during LOCKED -> next edge all outputs 0 except iserdes_rst=1, state IDLE.

Source files
------------

// File: rtl/adc_align_ctrl.sv
// Frame-alignment controller for the ADC LVDS capture path (CLKDIV domain).
// Optional statistics counters (relock_count, fail_count) are enabled by `define ADC_ALIGN_STATS_EN.
//
// state  | meaning
// IDLE   | alignment disabled, ISERDES held in reset
// SRST   | ISERDES reset pulse, RST_CYC cycles
// SETTLE | wait SETTLE_CYC cycles after reset or slip
// CHECK  | single compare of frmData against FRAME_PATTERN
// SLIP   | one-cycle bitslip to every lane
// VERIFY | qualify LOCK_CNT consecutive matches
// LOCKED | aligned, tolerate up to ERR_LIMIT-1 consecutive errors
// FAIL   | no alignment within MAX_SLIPS, hold until disabled
module adc_align_ctrl #(
    parameter logic [7:0] FRAME_PATTERN = 8'hF0,
    parameter int         RST_CYC       = 8,
    parameter int         SETTLE_CYC    = 4,
    parameter int         MAX_SLIPS     = 8,
    parameter int         LOCK_CNT      = 16,
    parameter int         ERR_LIMIT     = 4
) (
    input  logic       CLKDIV,
    input  logic       RST,
    input  logic       adc_en,
    input  logic [7:0] frmData,
    output logic       iserdes_rst,
    output logic       bitslip,
    output logic       locked,
    output logic       align_fail,
    output logic [3:0] slip_count
`ifdef ADC_ALIGN_STATS_EN
    ,
    output logic [7:0] relock_count,
    output logic [7:0] fail_count
`endif
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    localparam logic [7:0]    RST_LOAD    = 8'(RST_CYC - 1);
    localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [3:0]    SLIP_MAX    = 4'(MAX_SLIPS);
    localparam logic [MW-1:0] LOCK_TC     = MW'(LOCK_CNT);
    localparam logic [EW-1:0] ERR_TC      = EW'(ERR_LIMIT);

    typedef enum logic [2:0] {
        IDLE, SRST, SETTLE, CHECK, SLIP, VERIFY, LOCKED, FAIL
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    tmr, tmr_nxt;
    logic [MW-1:0] match_cnt, match_nxt;
    logic [EW-1:0] err_cnt, err_nxt;
    logic [3:0]    slip_nxt;
    logic          match, can_slip;

    assign match    = (frmData == FRAME_PATTERN);
    assign can_slip = (slip_count < SLIP_MAX);

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        match_nxt = match_cnt;
        err_nxt   = err_cnt;
        slip_nxt  = slip_count;
        if (!adc_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SRST;
                    tmr_nxt   = RST_LOAD;
                    slip_nxt  = '0;
                end
                SRST: begin
                    if (tmr == '0) begin
                        state_nxt = SETTLE;
                        tmr_nxt   = SETTLE_LOAD;
                    end else begin
                        tmr_nxt = tmr - 8'd1;
                    end
                end
                SETTLE: begin
                    if (tmr == '0) state_nxt = CHECK;
                    else           tmr_nxt   = tmr - 8'd1;
                end
                CHECK: begin
                    if (match) begin
                        state_nxt = VERIFY;
                        match_nxt = '0;
                    end else if (can_slip) begin
                        state_nxt = SLIP;
                        slip_nxt  = slip_count + 4'd1;
                    end else begin
                        state_nxt = FAIL;
                    end
                end
                SLIP: begin
                    state_nxt = SETTLE;
                    tmr_nxt   = SETTLE_LOAD;
                end
                VERIFY: begin
                    // Lock is declared on the edge after the count is reached.
                    if (match_cnt == LOCK_TC) begin
                        state_nxt = LOCKED;
                        match_nxt = '0;
                        err_nxt   = '0;
                    end else if (match) begin
                        match_nxt = match_cnt + 1'b1;
                    end else begin
                        match_nxt = '0;
                        if (can_slip) begin
                            state_nxt = SLIP;
                            slip_nxt  = slip_count + 4'd1;
                        end else begin
                            state_nxt = FAIL;
                        end
                    end
                end
                LOCKED: begin
                    if (err_cnt == ERR_TC) begin
                        state_nxt = SETTLE;
                        tmr_nxt   = SETTLE_LOAD;
                        err_nxt   = '0;
                        slip_nxt  = '0;
                    end else if (match) begin
                        err_nxt = '0;
                    end else begin
                        err_nxt = err_cnt + 1'b1;
                    end
                end
                FAIL: state_nxt = FAIL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            state       <= IDLE;
            tmr         <= '0;
            match_cnt   <= '0;
            err_cnt     <= '0;
            slip_count  <= '0;
            iserdes_rst <= 1'b1;
            bitslip     <= 1'b0;
            locked      <= 1'b0;
            align_fail  <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            match_cnt   <= match_nxt;
            err_cnt     <= err_nxt;
            slip_count  <= slip_nxt;
            iserdes_rst <= (state_nxt == IDLE) || (state_nxt == SRST);
            bitslip     <= (state_nxt == SLIP);
            locked      <= (state_nxt == LOCKED);
            align_fail  <= (state_nxt == FAIL);
        end
    end

`ifdef ADC_ALIGN_STATS_EN
    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            relock_count <= '0;
            fail_count   <= '0;
        end else begin
            if (state == LOCKED && state_nxt == SETTLE && relock_count != 8'hFF)
                relock_count <= relock_count + 8'd1;
            if (state != FAIL && state_nxt == FAIL && fail_count != 8'hFF)
                fail_count <= fail_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Directed self-checking bench for adc_align_ctrl; edge numbers count from the
// first rising edge that samples adc_en high.
module tb_adc_align_ctrl;

    logic       CLKDIV = 1'b0;
    logic       RST = 1'b1;
    logic       adc_en = 1'b0;
    logic [7:0] frmData = 8'hF0;
    logic       iserdes_rst, bitslip, locked, align_fail;
    logic [3:0] slip_count;
`ifdef ADC_ALIGN_STATS_EN
    logic [7:0] relock_count, fail_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;
    int n_slips = 0;
    int n_rst_hi = 0;
    int min_gap = 1000;
    int last_bs = -1000;
    int mode = 0;

    always #5 CLKDIV = ~CLKDIV;

    adc_align_ctrl dut (
        .CLKDIV      (CLKDIV),
        .RST         (RST),
        .adc_en      (adc_en),
        .frmData     (frmData),
        .iserdes_rst (iserdes_rst),
        .bitslip     (bitslip),
        .locked      (locked),
        .align_fail  (align_fail),
        .slip_count  (slip_count)
`ifdef ADC_ALIGN_STATS_EN
        ,
        .relock_count(relock_count),
        .fail_count  (fail_count)
`endif
    );

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int r);
        rotl8 = (x << r) | (x >> (8 - r));
    endfunction

    // mode 1 models a frame channel misaligned by 3 that rotates back one bit per slip
    task automatic tick();
        @(posedge CLKDIV);
        #1;
        edge_n++;
        if (bitslip) begin
            n_slips++;
            if (last_bs > -1000 && (edge_n - last_bs) < min_gap) min_gap = edge_n - last_bs;
            last_bs = edge_n;
        end
        if (iserdes_rst) n_rst_hi++;
        if (mode == 1) frmData = rotl8(8'hF0, (n_slips >= 3) ? 0 : 3 - n_slips);
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic start();
        adc_en   = 1'b1;
        edge_n   = -1;
        n_slips  = 0;
        n_rst_hi = 0;
        min_gap  = 1000;
        last_bs  = -1000;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_iserdes", int'(iserdes_rst), 1);
        chk("rst_bitslip", int'(bitslip), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fail", int'(align_fail), 0);
        chk("rst_slipcnt", int'(slip_count), 0);
        RST = 1'b0;
        tick();

        // aligned stream
        frmData = 8'hF0;
        start();
        run_to(7);
        chk("a_iserdes_e7", int'(iserdes_rst), 1);
        run_to(9);
        chk("a_iserdes_e9", int'(iserdes_rst), 0);
        run_to(29);
        chk("a_locked_e29", int'(locked), 0);
        run_to(30);
        chk("a_locked_e30", int'(locked), 1);
        chk("a_nslips", n_slips, 0);
        chk("a_slipcnt", int'(slip_count), 0);

        // lock-loss tolerance: 3 errors then a match
        frmData = 8'hAA;
        run_to(33);
        frmData = 8'hF0;
        run_to(35);
        chk("d_hold_lock", int'(locked), 1);
        frmData = 8'hAA;
        run_to(39);
        chk("d_locked_e39", int'(locked), 1);
        n_rst_hi = 0;
        frmData = 8'hF0;
        tick();
        chk("d_locked_e40", int'(locked), 0);
        chk("d_slipcnt", int'(slip_count), 0);
        run_to(61);
        chk("d_relock_e61", int'(locked), 0);
        run_to(62);
        chk("d_relock_e62", int'(locked), 1);
        chk("d_no_iserdes", n_rst_hi, 0);
`ifdef ADC_ALIGN_STATS_EN
        chk("d_relock_count", int'(relock_count), 1);
`endif
        adc_en = 1'b0;
        tick();
        chk("d_dis_locked", int'(locked), 0);
        chk("d_dis_iserdes", int'(iserdes_rst), 1);

        // misaligned by 3
        mode = 1;
        start();
        frmData = rotl8(8'hF0, 3);
        run_to(13);
        chk("b_bs_e13", int'(bitslip), 1);
        run_to(14);
        chk("b_bs_e14", int'(bitslip), 0);
        run_to(47);
        chk("b_locked_e47", int'(locked), 0);
        run_to(48);
        chk("b_locked_e48", int'(locked), 1);
        chk("b_nslips", n_slips, 3);
        chk("b_slipcnt", int'(slip_count), 3);
        chk("b_min_gap", min_gap, 6);
        adc_en = 1'b0;
        mode = 0;
        tick();

        // VERIFY glitch on the 10th match
        frmData = 8'hF0;
        start();
        run_to(22);
        frmData = 8'hAA;
        tick();
        chk("e_bs_e23", int'(bitslip), 1);
        chk("e_slipcnt", int'(slip_count), 1);
        frmData = 8'hF0;
        run_to(45);
        chk("e_locked_e45", int'(locked), 0);
        run_to(46);
        chk("e_locked_e46", int'(locked), 1);
        chk("e_nslips", n_slips, 1);
        adc_en = 1'b0;
        tick();

        // no pattern
        frmData = 8'hAA;
        start();
        run_to(60);
        chk("c_fail_e60", int'(align_fail), 0);
        run_to(61);
        chk("c_fail_e61", int'(align_fail), 1);
        chk("c_nslips", n_slips, 8);
        chk("c_slipcnt", int'(slip_count), 8);
        chk("c_locked", int'(locked), 0);
        run_to(70);
        chk("c_fail_hold", int'(align_fail), 1);
        chk("c_slipcnt_hold", int'(slip_count), 8);
`ifdef ADC_ALIGN_STATS_EN
        chk("c_fail_count", int'(fail_count), 1);
`endif
        adc_en = 1'b0;
        tick();
        chk("c_dis_fail", int'(align_fail), 0);
        chk("c_dis_iserdes", int'(iserdes_rst), 1);

        // RST during SLIP
        frmData = 8'hAA;
        start();
        run_to(13);
        chk("f_bs_e13", int'(bitslip), 1);
        chk("f_slipcnt_e13", int'(slip_count), 1);
        RST = 1'b1;
        tick();
        chk("f_rst_bs", int'(bitslip), 0);
        chk("f_rst_slipcnt", int'(slip_count), 0);
        chk("f_rst_iserdes", int'(iserdes_rst), 1);
        chk("f_rst_fail", int'(align_fail), 0);

        // RST during LOCKED
        frmData = 8'hF0;
        RST = 1'b0;
        start();
        run_to(30);
        chk("g_locked_e30", int'(locked), 1);
        RST = 1'b1;
        tick();
        chk("g_rst_locked", int'(locked), 0);
        chk("g_rst_iserdes", int'(iserdes_rst), 1);
        chk("g_rst_bs", int'(bitslip), 0);
        chk("g_rst_slipcnt", int'(slip_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
